sccb_responder: RTL and testbench

SCCB_RESPONDER -- requirements
Module: sccb_responder

---
 rtl/sccb_responder.sv | 130 +++++++++++++
 tb/tb_sccb_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_responder.sv
// sccb_responder: SCCB write-only responder decoding 3-phase register writes.
module sccb_responder #(
  parameter logic [7:0] DEV_ADDR = 8'h42,
  parameter bit         ACK_EN   = 1'b1
) (
  input  logic       camera_clk,
  input  logic       rst,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, DEV, REG, DATA, DONE, IGNORE} state_t;
  state_t state_q, state_d;
  logic [2:0] scl_q, scl_d, sda_q, sda_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] sh_q, sh_d;
  logic [7:0] adr_q, adr_d, dat_q, dat_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic pend_q, pend_d, oe_q, oe_d, wv_q, wv_d, err_q, err_d, busy_q, busy_d;
  logic scl, sda, rise, fall, start, stop, phase;
  logic [7:0] rx;
  // [1] is the synchronised level, [2] its one-cycle history
  assign scl   = scl_q[1];
  assign sda   = sda_q[1];
  assign rise  = scl & ~scl_q[2];
  assign fall  = ~scl & scl_q[2];
  assign start = scl & scl_q[2] & sda_q[2] & ~sda;
  assign stop  = scl & scl_q[2] & ~sda_q[2] & sda;
  assign phase = (state_q == DEV) || (state_q == REG) || (state_q == DATA);
  assign rx    = {sh_q, sda};
  // pend marks the 9th bit sampled in a phase, or a SIOC high seen in DONE
  always_comb begin
    scl_d     = {scl_q[1:0], sioc};
    sda_d     = {sda_q[1:0], siod_in};
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    sh_d      = sh_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    oe_d      = oe_q;
    wv_d      = 1'b0;
    err_d     = 1'b0;
    if (start) begin
      state_d = DEV;
      cnt_d   = '0;
      pend_d  = 1'b0;
      oe_d    = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
      oe_d    = 1'b0;
      err_d   = phase;
      wv_d    = state_q == DONE;
      wr_addr_d = state_q == DONE ? adr_q : wr_addr_q;
      wr_data_d = state_q == DONE ? dat_q : wr_data_q;
    end else if (phase) begin
      if (rise && !pend_q) begin
        sh_d   = rx[6:0];
        cnt_d  = cnt_q == 4'd8 ? cnt_q : cnt_q + 4'd1;
        pend_d = cnt_q == 4'd8;
        if (cnt_q == 4'd7 && state_q == DEV && rx != DEV_ADDR) state_d = IGNORE;
        if (cnt_q == 4'd7 && state_q == REG) adr_d = rx;
        if (cnt_q == 4'd7 && state_q == DATA) dat_d = rx;
      end
      if (fall) begin
        oe_d = ACK_EN && !pend_q && cnt_q == 4'd8;
        if (pend_q) begin
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = state_q == DEV ? REG : state_q == REG ? DATA : DONE;
        end
      end
    end else if (state_q == DONE) begin
      if (rise) pend_d = 1'b1;
      if (fall && pend_q) begin
        err_d   = 1'b1;
        pend_d  = 1'b0;
        state_d = IGNORE;
      end
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge camera_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      scl_q     <= '1;
      sda_q     <= '1;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      sh_q      <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      oe_q      <= 1'b0;
      wv_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      sh_q      <= sh_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      oe_q      <= oe_d;
      wv_q      <= wv_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end
  assign siod_oe  = oe_q;
  assign wr_valid = wv_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign err      = err_q;
endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: drives SCCB frames at camera_clk/64 and scoreboards the decoded writes.
module tb_sccb_responder;
  logic clk = 1'b0, rst = 1'b1, sioc = 1'b1, siod_m = 1'b1;
  logic siod_in, siod_oe, wr_valid, busy, err;
  logic [7:0] wr_addr, wr_data;
  int vectors = 0, miscompares = 0;
  logic [15:0] exp_q[$], got_q[$];
  int oe_lens[$];
  int got_rd = 0, err_n = 0, oe_cur = 0, oe_bad = 0;
  assign siod_in = siod_m & ~siod_oe;
  always #5 clk = ~clk;
  sccb_responder #(.DEV_ADDR(8'h42), .ACK_EN(1'b1)) dut (
    .camera_clk(clk), .rst(rst), .sioc(sioc), .siod_in(siod_in), .siod_oe(siod_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .err(err)
  );
  always @(negedge clk) begin
    if (wr_valid) got_q.push_back({wr_addr, wr_data});
    if (err) err_n <= err_n + 1;
    if (siod_oe && !busy) oe_bad <= oe_bad + 1;
    if (siod_oe) oe_cur <= oe_cur + 1;
    else if (oe_cur != 0) begin
      oe_lens.push_back(oe_cur);
      oe_cur <= 0;
    end
  end
  task automatic wc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic s_start();
    siod_m = 1'b1; wc(16); sioc = 1'b1; wc(16); siod_m = 1'b0; wc(16); sioc = 1'b0; wc(16);
  endtask
  task automatic s_bit(input logic b);
    siod_m = b; wc(16); sioc = 1'b1; wc(32); sioc = 1'b0; wc(16);
  endtask
  task automatic s_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) s_bit(b[i]);
    s_bit(1'b1);
  endtask
  task automatic s_stop();
    siod_m = 1'b0; wc(16); sioc = 1'b1; wc(16); siod_m = 1'b1; wc(32);
  endtask
  task automatic s_write(input logic [7:0] dv, input logic [7:0] a, input logic [7:0] d);
    s_start(); s_byte(dv); s_byte(a); s_byte(d); s_stop(); wc(8);
  endtask
  task automatic drain(input string tag);
    logic [15:0] g, e;
    while (got_rd < got_q.size()) begin
      g = got_q[got_rd];
      got_rd++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s unexpected wr_valid got %h required none", tag, g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          miscompares++;
          $display("FAIL %s addr/data got %h required %h", tag, g, e);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s missing wr_valid got %0d pending required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset();
    rst = 1'b1; wc(3);
    vectors++;
    if ({siod_oe, wr_valid, err, busy} !== 4'b0) begin
      miscompares++; $display("FAIL reset_flags got %b required 0000", {siod_oe, wr_valid, err, busy});
    end
    vectors++;
    if ({wr_addr, wr_data} !== 16'h0) begin
      miscompares++; $display("FAIL reset_data got %h required 0000", {wr_addr, wr_data});
    end
    rst = 1'b0; wc(8);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b required 0", busy); end
  endtask
  task automatic test_write();
    int e0, n0;
    e0 = err_n; n0 = oe_lens.size();
    exp_q.push_back({8'h12, 8'h80});
    s_start();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_after_start got %b required 1", busy); end
    s_byte(8'h42); s_byte(8'h12); s_byte(8'h80);
    siod_m = 1'b0; wc(16); sioc = 1'b1; wc(16); siod_m = 1'b1; wc(2);
    vectors++;
    if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL wv_edge2 got %b required 0", wr_valid); end
    wc(1);
    vectors++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'h12, 8'h80}) begin
      miscompares++; $display("FAIL wv_edge3 got %b/%h/%h required 1/12/80", wr_valid, wr_addr, wr_data);
    end
    wc(1);
    vectors++;
    if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL wv_pulse_width got %b required 0", wr_valid); end
    wc(30);
    drain("write_42_12_80");
    vectors++;
    if (err_n != e0) begin miscompares++; $display("FAIL write_err got %0d required 0", err_n - e0); end
    vectors++;
    if (oe_lens.size() - n0 != 3) begin
      miscompares++; $display("FAIL ack_windows got %0d required 3", oe_lens.size() - n0);
    end
    for (int i = n0; i < oe_lens.size(); i++) begin
      vectors++;
      if (oe_lens[i] != 64) begin miscompares++; $display("FAIL ack_len got %0d required 64", oe_lens[i]); end
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_after_stop got %b required 0", busy); end
  endtask
  task automatic test_bad_dev();
    int e0, n0;
    e0 = err_n; n0 = oe_lens.size();
    s_start(); s_byte(8'h60);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL ignore_busy got %b required 1", busy); end
    s_byte(8'h12); s_byte(8'h34); s_stop(); wc(8);
    drain("bad_dev_60");
    vectors++;
    if (err_n != e0) begin miscompares++; $display("FAIL bad_dev_err got %0d required 0", err_n - e0); end
    vectors++;
    if (oe_lens.size() != n0 || oe_cur != 0) begin
      miscompares++; $display("FAIL bad_dev_ack got %0d required 0", oe_lens.size() - n0);
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL bad_dev_busy got %b required 0", busy); end
  endtask
  task automatic test_read();
    int e0, n0;
    e0 = err_n; n0 = oe_lens.size();
    s_start(); s_byte(8'h43); s_byte(8'h12); s_stop(); wc(8);
    vectors++;
    if (oe_lens.size() != n0) begin
      miscompares++; $display("FAIL read_ack got %0d required 0", oe_lens.size() - n0);
    end
    exp_q.push_back({8'h3A, 8'h04});
    s_write(8'h42, 8'h3A, 8'h04);
    drain("read_then_write");
    vectors++;
    if (err_n != e0) begin miscompares++; $display("FAIL read_err got %0d required 0", err_n - e0); end
    wc(100);
    vectors++;
    if ({wr_addr, wr_data} !== 16'h3A04) begin
      miscompares++; $display("FAIL hold_after_write got %h required 3a04", {wr_addr, wr_data});
    end
  endtask
  task automatic test_early_stop();
    int e0;
    e0 = err_n;
    s_start(); s_byte(8'h42); s_byte(8'h11); s_stop(); wc(8);
    drain("early_stop");
    vectors++;
    if (err_n - e0 != 1) begin miscompares++; $display("FAIL early_stop_err got %0d required 1", err_n - e0); end
    vectors++;
    if ({wr_addr, wr_data} !== 16'h3A04) begin
      miscompares++; $display("FAIL early_stop_hold got %h required 3a04", {wr_addr, wr_data});
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL early_stop_busy got %b required 0", busy); end
  endtask
  task automatic test_back_to_back();
    int e0;
    logic [4:0] part;
    e0 = err_n; part = 5'b10110;
    s_start(); s_byte(8'h42); s_byte(8'h55);
    for (int i = 4; i >= 0; i--) s_bit(part[i]);
    exp_q.push_back({8'h40, 8'hD0});
    s_write(8'h42, 8'h40, 8'hD0);
    drain("repeated_start");
    vectors++;
    if (err_n != e0) begin miscompares++; $display("FAIL repeated_start_err got %0d required 0", err_n - e0); end
  endtask
  task automatic test_extra_bit();
    int e0;
    e0 = err_n;
    s_start(); s_byte(8'h42); s_byte(8'h20); s_byte(8'h30); s_bit(1'b0); s_stop(); wc(8);
    drain("extra_bit");
    vectors++;
    if (err_n - e0 != 1) begin miscompares++; $display("FAIL extra_bit_err got %0d required 1", err_n - e0); end
    vectors++;
    if ({wr_addr, wr_data} !== 16'h40D0) begin
      miscompares++; $display("FAIL extra_bit_hold got %h required 40d0", {wr_addr, wr_data});
    end
  endtask
  task automatic test_mid_reset();
    int e0;
    s_start(); s_byte(8'h42);
    s_bit(1'b0); s_bit(1'b1); s_bit(1'b1); s_bit(1'b1);
    rst = 1'b1; wc(1); rst = 1'b0;
    vectors++;
    if ({siod_oe, wr_valid, err, busy, wr_addr, wr_data} !== 20'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got %b/%h/%h required 0000/00/00", {siod_oe, wr_valid, err, busy}, wr_addr, wr_data);
    end
    e0 = err_n;
    s_bit(1'b0); s_bit(1'b1); s_bit(1'b1); s_bit(1'b1); s_bit(1'b1);
    s_byte(8'h99); s_stop(); wc(8);
    drain("mid_reset");
    vectors++;
    if (err_n != e0) begin miscompares++; $display("FAIL mid_reset_err got %0d required 0", err_n - e0); end
    vectors++;
    if ({busy, wr_addr, wr_data} !== 17'h0) begin
      miscompares++; $display("FAIL mid_reset_after got %b/%h/%h required 0/00/00", busy, wr_addr, wr_data);
    end
  endtask
  initial begin
    test_reset();
    test_write();
    test_bad_dev();
    test_read();
    test_early_stop();
    test_back_to_back();
    test_extra_bit();
    test_mid_reset();
    vectors++;
    if (oe_bad != 0) begin miscompares++; $display("FAIL oe_while_idle got %0d required 0", oe_bad); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
